// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Brief    : Hazard-control, redirect, instruction-memory and IF/ID bundle
//            for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        misalign_d;
    logic [31:0] fetch_count;

    modport master (
        input  stall_f, stall_d, flush_d, redirect, redirect_target, imem_rdata,
        output imem_addr, pc_f, instr_d, pc_d, pcplus4_d, valid_d, misalign_d,
               fetch_count
    );

    modport slave (
        output stall_f, stall_d, flush_d, redirect, redirect_target, imem_rdata,
        input  imem_addr, pc_f, instr_d, pc_d, pcplus4_d, valid_d, misalign_d,
               fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : IF stage: PC register, next-PC selection, IF/ID pipeline
//            register, misaligned-redirect flag and retired-fetch counter.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    fetch_stage_if.master bus
);

    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;
    logic        r_misalign;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pcplus4;
    logic        w_misaligned_target;

    assign w_pcplus4           = r_pc + 32'd4;
    assign w_misaligned_target = bus.redirect && (bus.redirect_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= RESET_VECTOR;
            r_instr_d     <= NOP_INSTR;
            r_pc_d        <= 32'd0;
            r_pcplus4_d   <= 32'd0;
            r_valid_d     <= 1'b0;
            r_misalign    <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            // A redirect wins over stall_f so a taken branch is never dropped.
            if (bus.redirect) begin
                r_pc <= {bus.redirect_target[31:2], 2'b00};
            end else if (!bus.stall_f) begin
                r_pc <= w_pcplus4;
            end

            if (bus.flush_d) begin
                r_instr_d   <= NOP_INSTR;
                r_pc_d      <= 32'd0;
                r_pcplus4_d <= 32'd0;
                r_valid_d   <= 1'b0;
            end else if (!bus.stall_d) begin
                r_instr_d     <= bus.imem_rdata;
                r_pc_d        <= r_pc;
                r_pcplus4_d   <= w_pcplus4;
                r_valid_d     <= 1'b1;
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            if (w_misaligned_target) begin
                r_misalign <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = {2'b00, r_pc[31:2]};
    assign bus.pc_f        = r_pc;
    assign bus.instr_d     = r_instr_d;
    assign bus.pc_d        = r_pc_d;
    assign bus.pcplus4_d   = r_pcplus4_d;
    assign bus.valid_d     = r_valid_d;
    assign bus.misalign_d  = r_misalign;
    assign bus.fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Self-checking bench for fetch_stage with an IF/ID scoreboard.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        valid;
        logic [31:0] cnt;
    } ifid_t;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    ifid_t       sb[$];
    ifid_t       cur;
    logic [31:0] exp_pc;
    logic        exp_mis;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_VECTOR (32'h0000_0000),
        .NOP_INSTR    (c_NOP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] idx);
        if (idx == 32'd0)      return 32'h0050_0093;
        else if (idx == 32'd1) return 32'h0010_0113;
        else                   return 32'hC0DE_0000 ^ idx;
    endfunction

    // Combinational instruction memory model
    always_comb bus.imem_rdata = instr_at(bus.imem_addr);

    task automatic model_reset();
        exp_pc    = 32'h0;
        exp_mis   = 1'b0;
        cur.instr = c_NOP;
        cur.pc    = 32'h0;
        cur.pcp4  = 32'h0;
        cur.valid = 1'b0;
        cur.cnt   = 32'h0;
    endtask

    task automatic cycle(input logic rd, input logic [31:0] tgt,
                         input logic sf, input logic sd, input logic fd);
        ifid_t       e;
        logic [31:0] nxt;
        bus.redirect        = rd;
        bus.redirect_target = tgt;
        bus.stall_f         = sf;
        bus.stall_d         = sd;
        bus.flush_d         = fd;
        if (fd) begin
            e.instr = c_NOP; e.pc = 32'h0; e.pcp4 = 32'h0; e.valid = 1'b0; e.cnt = cur.cnt;
        end else if (sd) begin
            e = cur;
        end else begin
            e.instr = instr_at({2'b00, exp_pc[31:2]});
            e.pc    = exp_pc;
            e.pcp4  = exp_pc + 32'd4;
            e.valid = 1'b1;
            e.cnt   = cur.cnt + 32'd1;
        end
        sb.push_back(e);
        if (rd)      nxt = {tgt[31:2], 2'b00};
        else if (sf) nxt = exp_pc;
        else         nxt = exp_pc + 32'd4;
        if (rd && tgt[1:0] != 2'b00) exp_mis = 1'b1;
        @(posedge clk);
        #1;
        exp_pc = nxt;
        cur    = sb.pop_front();
        total++; if (bus.pc_f !== exp_pc) begin bad++; $display("FAIL pc_f got=%h exp=%h", bus.pc_f, exp_pc); end
        total++; if (bus.imem_addr !== {2'b00, exp_pc[31:2]}) begin bad++; $display("FAIL imem_addr got=%h exp=%h", bus.imem_addr, {2'b00, exp_pc[31:2]}); end
        total++; if (bus.instr_d !== cur.instr) begin bad++; $display("FAIL sb_instr_d got=%h exp=%h", bus.instr_d, cur.instr); end
        total++; if (bus.pc_d !== cur.pc) begin bad++; $display("FAIL sb_pc_d got=%h exp=%h", bus.pc_d, cur.pc); end
        total++; if (bus.pcplus4_d !== cur.pcp4) begin bad++; $display("FAIL sb_pcplus4_d got=%h exp=%h", bus.pcplus4_d, cur.pcp4); end
        total++; if (bus.valid_d !== cur.valid) begin bad++; $display("FAIL sb_valid_d got=%b exp=%b", bus.valid_d, cur.valid); end
        total++; if (bus.fetch_count !== cur.cnt) begin bad++; $display("FAIL sb_fetch_count got=%0d exp=%0d", bus.fetch_count, cur.cnt); end
        total++; if (bus.misalign_d !== exp_mis) begin bad++; $display("FAIL misalign_d got=%b exp=%b", bus.misalign_d, exp_mis); end
        bus.redirect = 1'b0; bus.redirect_target = 32'h0;
        bus.stall_f  = 1'b0; bus.stall_d = 1'b0; bus.flush_d = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        total++; if (bus.pc_f !== 32'h0) begin bad++; $display("FAIL %s pc_f got=%h exp=0", tag, bus.pc_f); end
        total++; if (bus.instr_d !== c_NOP) begin bad++; $display("FAIL %s instr_d got=%h exp=%h", tag, bus.instr_d, c_NOP); end
        total++; if (bus.pc_d !== 32'h0 || bus.pcplus4_d !== 32'h0) begin bad++; $display("FAIL %s pc_d/pcplus4_d got=%h/%h exp=0/0", tag, bus.pc_d, bus.pcplus4_d); end
        total++; if (bus.valid_d !== 1'b0 || bus.misalign_d !== 1'b0) begin bad++; $display("FAIL %s valid/misalign got=%b/%b exp=0/0", tag, bus.valid_d, bus.misalign_d); end
        total++; if (bus.fetch_count !== 32'h0) begin bad++; $display("FAIL %s fetch_count got=%0d exp=0", tag, bus.fetch_count); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.redirect = 1'b0; bus.redirect_target = 32'h0;
        bus.stall_f  = 1'b0; bus.stall_d = 1'b0; bus.flush_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_free_run();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.instr_d !== 32'h0050_0093 || bus.valid_d !== 1'b1) begin bad++; $display("FAIL free_run_e1 instr/valid got=%h/%b exp=00500093/1", bus.instr_d, bus.valid_d); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.pc_f !== 32'h8 || bus.instr_d !== 32'h0010_0113 || bus.fetch_count !== 32'd2) begin bad++; $display("FAIL free_run_e2 pc/instr/cnt got=%h/%h/%0d exp=8/00100113/2", bus.pc_f, bus.instr_d, bus.fetch_count); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        total++; if (bus.pc_f !== 32'h8 || bus.instr_d !== 32'h0010_0113 || bus.fetch_count !== 32'd2) begin bad++; $display("FAIL stall_hold pc/instr/cnt got=%h/%h/%0d exp=8/00100113/2", bus.pc_f, bus.instr_d, bus.fetch_count); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.pc_f !== 32'hC || bus.pc_d !== 32'h8) begin bad++; $display("FAIL stall_release pc_f/pc_d got=%h/%h exp=c/8", bus.pc_f, bus.pc_d); end
    endtask

    task automatic test_redirect_flush();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        total++; if (bus.pc_f !== 32'h40 || bus.instr_d !== c_NOP || bus.valid_d !== 1'b0) begin bad++; $display("FAIL br_flush pc/instr/valid got=%h/%h/%b exp=40/00000013/0", bus.pc_f, bus.instr_d, bus.valid_d); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.pc_d !== 32'h40 || bus.valid_d !== 1'b1) begin bad++; $display("FAIL br_target pc_d/valid got=%h/%b exp=40/1", bus.pc_d, bus.valid_d); end
    endtask

    task automatic test_misalign();
        cycle(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
        total++; if (bus.pc_f !== 32'h40 || bus.misalign_d !== 1'b1) begin bad++; $display("FAIL misalign_set pc/flag got=%h/%b exp=40/1", bus.pc_f, bus.misalign_d); end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.misalign_d !== 1'b1) begin bad++; $display("FAIL misalign_sticky got=%b exp=1", bus.misalign_d); end
    endtask

    task automatic test_redirect_stall();
        cycle(1'b1, 32'h80, 1'b1, 1'b1, 1'b0);
        total++; if (bus.pc_f !== 32'h80 || bus.pc_d !== 32'h48) begin bad++; $display("FAIL redir_stall pc_f/pc_d got=%h/%h exp=80/48", bus.pc_f, bus.pc_d); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.pc_f !== 32'h24) begin bad++; $display("FAIL pre_reset pc_f got=%h exp=24", bus.pc_f); end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.pc_f !== 32'h4 || bus.instr_d !== 32'h0050_0093) begin bad++; $display("FAIL resume pc/instr got=%h/%h exp=4/00500093", bus.pc_f, bus.instr_d); end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        total++; if (bus.pc_f !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pre pc_f got=%h exp=fffffffc", bus.pc_f); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (bus.pc_f !== 32'h0 || bus.pc_d !== 32'hFFFF_FFFC || bus.pcplus4_d !== 32'h0) begin bad++; $display("FAIL wrap pc_f/pc_d/pcp4 got=%h/%h/%h exp=0/fffffffc/0", bus.pc_f, bus.pc_d, bus.pcplus4_d); end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_flush();
        test_misalign();
        test_redirect_stall();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
